// File: rtl/perceptron_train.sv
// ---------------------------------------------------------------------------
// perceptron_train
//
// Write-side engine of the perceptron branch predictor. Resolved-branch
// records from retire are queued in a small FIFO. The record at the head is
// either retired immediately (prediction was confident and correct) or used
// to train its weight row: read row, apply the saturating +/-1 perceptron
// rule to every weight, write the row back. Records retire strictly in
// arrival order, so two records hitting the same row see each other's
// updates.
//
// Optional build macro: PERCEPTRON_TRAIN_STAT_EN adds the saturating
// train_cnt_o / skip_cnt_o statistics counters.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o   record handshake into the FIFO
//   req_idx_i, req_bhr_i,       table row, history snapshot, predicted sum
//   req_sum_i, req_taken_i      and actual outcome of the resolved branch
//   rd_en_o, rd_idx_o           one-cycle table read request
//   rd_weight_i                 row data, valid the cycle after rd_en_o
//   wr_en_o, wr_idx_o,          write-back request, held until wr_ready_i
//   wr_weight_o, wr_ready_i
//   busy_o                      engine working or records still queued
//   train_cnt_o, skip_cnt_o     (macro only) rows written / records skipped
// ---------------------------------------------------------------------------
module perceptron_train #(
    parameter int BHR_W    = 8,
    parameter int WEIGHT_W = 8,
    parameter int SUM_W    = 12,
    parameter int PT_IDX_W = 6,
    parameter int THETA    = 29,
    parameter int Q_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [PT_IDX_W-1:0]             req_idx_i,
    input  logic [BHR_W-1:0]                req_bhr_i,
    input  logic [SUM_W-1:0]                req_sum_i,
    input  logic                            req_taken_i,
    output logic                            rd_en_o,
    output logic [PT_IDX_W-1:0]             rd_idx_o,
    input  logic [(BHR_W+1)*WEIGHT_W-1:0]   rd_weight_i,
    output logic                            wr_en_o,
    output logic [PT_IDX_W-1:0]             wr_idx_o,
    output logic [(BHR_W+1)*WEIGHT_W-1:0]   wr_weight_o,
    input  logic                            wr_ready_i,
    output logic                            busy_o
`ifdef PERCEPTRON_TRAIN_STAT_EN
    ,
    output logic [15:0]                     train_cnt_o,
    output logic [15:0]                     skip_cnt_o
`endif
);

    localparam int ROW_W = (BHR_W + 1) * WEIGHT_W;
    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] Q_FULL  = CNT_W'(Q_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Threshold in SUM_W+1 bits so that negating it and comparing against
    // the most-negative sum cannot wrap.
    localparam logic signed [SUM_W:0] THETA_POS = THETA[SUM_W:0];
    localparam logic signed [SUM_W:0] THETA_NEG = -THETA_POS;

    localparam logic [WEIGHT_W:0]   W_ONE = {{WEIGHT_W{1'b0}}, 1'b1};
    localparam logic [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CALC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Request FIFO. Storage is a handful of registers, so the head entry is
    // read combinationally and can be classified in the same cycle it shows
    // up. Contents need no reset; only pointers and count do.
    // -----------------------------------------------------------------------
    logic [PT_IDX_W-1:0] q_idx_mem   [Q_DEPTH];
    logic [BHR_W-1:0]    q_bhr_mem   [Q_DEPTH];
    logic [SUM_W-1:0]    q_sum_mem   [Q_DEPTH];
    logic                q_taken_mem [Q_DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic push;
    logic pop;
    logic fifo_nonempty;

    logic [PT_IDX_W-1:0] head_idx;
    logic [BHR_W-1:0]    head_bhr;
    logic [SUM_W-1:0]    head_sum;
    logic                head_taken;

    assign req_ready_o   = (count_reg < Q_FULL);
    assign fifo_nonempty = (count_reg != '0);
    assign push          = req_valid_i && req_ready_o;

    assign head_idx   = q_idx_mem[rd_ptr_reg];
    assign head_bhr   = q_bhr_mem[rd_ptr_reg];
    assign head_sum   = q_sum_mem[rd_ptr_reg];
    assign head_taken = q_taken_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx_mem[wr_ptr_reg]   <= req_idx_i;
            q_bhr_mem[wr_ptr_reg]   <= req_bhr_i;
            q_sum_mem[wr_ptr_reg]   <= req_sum_i;
            q_taken_mem[wr_ptr_reg] <= req_taken_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_ONE;
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_ONE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Train decision for the head record. A negative sum predicted taken.
    // Training is needed on a mispredict or when |sum| <= THETA.
    // -----------------------------------------------------------------------
    logic signed [SUM_W:0] head_sum_ext;
    logic                  head_pred;
    logic                  head_low_conf;
    logic                  head_trains;

    assign head_sum_ext  = {head_sum[SUM_W-1], head_sum};
    assign head_pred     = head_sum[SUM_W-1];
    assign head_low_conf = (head_sum_ext >= THETA_NEG) && (head_sum_ext <= THETA_POS);
    assign head_trains   = (head_pred != head_taken) || head_low_conf;

    // -----------------------------------------------------------------------
    // Control FSM with registered table-interface outputs.
    // -----------------------------------------------------------------------
    state_t              state_reg;
    logic                rd_en_reg;
    logic [PT_IDX_W-1:0] rd_idx_reg;
    logic                wr_en_reg;
    logic [PT_IDX_W-1:0] wr_idx_reg;
    logic [ROW_W-1:0]    wr_weight_reg;
    logic [BHR_W-1:0]    work_bhr_reg;
    logic                work_taken_reg;
    logic [ROW_W-1:0]    row_next;

    logic skip_pop;
    logic write_done;

    assign skip_pop   = (state_reg == ST_IDLE) && fifo_nonempty && !head_trains;
    assign write_done = (state_reg == ST_WRITE) && wr_ready_i;
    // The head stays in the FIFO until its processing completes, so its
    // slot cannot be reused while the row is in flight.
    assign pop        = skip_pop || write_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            rd_en_reg      <= 1'b0;
            rd_idx_reg     <= '0;
            wr_en_reg      <= 1'b0;
            wr_idx_reg     <= '0;
            wr_weight_reg  <= '0;
            work_bhr_reg   <= '0;
            work_taken_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (fifo_nonempty && head_trains) begin
                        state_reg      <= ST_READ;
                        rd_en_reg      <= 1'b1;
                        rd_idx_reg     <= head_idx;
                        work_bhr_reg   <= head_bhr;
                        work_taken_reg <= head_taken;
                    end
                end
                ST_READ: begin
                    rd_en_reg <= 1'b0;
                    state_reg <= ST_CALC;
                end
                ST_CALC: begin
                    wr_weight_reg <= row_next;
                    wr_idx_reg    <= rd_idx_reg;
                    wr_en_reg     <= 1'b1;
                    state_reg     <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (wr_ready_i) begin
                        wr_en_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    rd_en_reg <= 1'b0;
                    wr_en_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rd_en_o     = rd_en_reg;
    assign rd_idx_o    = rd_idx_reg;
    assign wr_en_o     = wr_en_reg;
    assign wr_idx_o    = wr_idx_reg;
    assign wr_weight_o = wr_weight_reg;
    assign busy_o      = (state_reg != ST_IDLE) || fifo_nonempty;

    // -----------------------------------------------------------------------
    // Weight update lanes. Input vector x = {bhr, 1}: lane 0 is the bias.
    // A weight moves towards the outcome: +1 when x[i] equals taken, -1
    // otherwise. One guard bit detects overflow; the two top bits differ
    // exactly when the result left the signed range, and the guard bit then
    // tells which rail to clamp to.
    // -----------------------------------------------------------------------
    logic [BHR_W:0] x_vec;
    assign x_vec = {work_bhr_reg, 1'b1};

    generate
        for (genvar gi = 0; gi <= BHR_W; gi++) begin : g_lane
            logic [WEIGHT_W-1:0] w_old;
            logic [WEIGHT_W:0]   w_ext;
            logic [WEIGHT_W:0]   w_adj;
            logic                w_inc;
            logic                w_ovf;

            assign w_old = rd_weight_i[gi*WEIGHT_W +: WEIGHT_W];
            assign w_ext = {w_old[WEIGHT_W-1], w_old};
            assign w_inc = (x_vec[gi] == work_taken_reg);
            assign w_adj = w_inc ? (w_ext + W_ONE) : (w_ext - W_ONE);
            assign w_ovf = (w_adj[WEIGHT_W] != w_adj[WEIGHT_W-1]);

            assign row_next[gi*WEIGHT_W +: WEIGHT_W] =
                w_ovf ? (w_adj[WEIGHT_W] ? W_MIN : W_MAX) : w_adj[WEIGHT_W-1:0];
        end
    endgenerate

`ifdef PERCEPTRON_TRAIN_STAT_EN
    // -----------------------------------------------------------------------
    // Statistics: rows written and records retired without training.
    // Both stick at all-ones instead of wrapping.
    // -----------------------------------------------------------------------
    logic [15:0] train_cnt_reg;
    logic [15:0] skip_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            train_cnt_reg <= '0;
            skip_cnt_reg  <= '0;
        end else begin
            if (write_done && (train_cnt_reg != 16'hFFFF)) begin
                train_cnt_reg <= train_cnt_reg + 16'd1;
            end
            if (skip_pop && (skip_cnt_reg != 16'hFFFF)) begin
                skip_cnt_reg <= skip_cnt_reg + 16'd1;
            end
        end
    end

    assign train_cnt_o = train_cnt_reg;
    assign skip_cnt_o  = skip_cnt_reg;
`endif

endmodule

// File: tb/tb_perceptron_train.sv
// ---------------------------------------------------------------------------
// tb_perceptron_train
//
// Self-checking bench for perceptron_train. A behavioural table memory
// answers reads and absorbs writes. A reference model (queue of accepted
// records plus a shadow copy of the weight table) predicts every read index
// and every written row from the training rules directly. Directed
// sequences cover timing, threshold boundaries, saturation, backpressure and
// reset during a write; a randomized phase then stresses ordering and
// same-row serialization.
// ---------------------------------------------------------------------------
module tb_perceptron_train;

    localparam int BHR_W    = 8;
    localparam int WEIGHT_W = 8;
    localparam int SUM_W    = 12;
    localparam int PT_IDX_W = 6;
    localparam int THETA    = 29;
    localparam int Q_DEPTH  = 4;
    localparam int ROW_W    = (BHR_W + 1) * WEIGHT_W;
    localparam int ROWS     = 1 << PT_IDX_W;

    logic                clk;
    logic                rst_n;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [PT_IDX_W-1:0] req_idx_i;
    logic [BHR_W-1:0]    req_bhr_i;
    logic [SUM_W-1:0]    req_sum_i;
    logic                req_taken_i;
    logic                rd_en_o;
    logic [PT_IDX_W-1:0] rd_idx_o;
    logic [ROW_W-1:0]    rd_weight_i;
    logic                wr_en_o;
    logic [PT_IDX_W-1:0] wr_idx_o;
    logic [ROW_W-1:0]    wr_weight_o;
    logic                wr_ready_i;
    logic                busy_o;
`ifdef PERCEPTRON_TRAIN_STAT_EN
    logic [15:0]         train_cnt;
    logic [15:0]         skip_cnt;
`endif

    perceptron_train #(
        .BHR_W(BHR_W), .WEIGHT_W(WEIGHT_W), .SUM_W(SUM_W),
        .PT_IDX_W(PT_IDX_W), .THETA(THETA), .Q_DEPTH(Q_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_idx_i(req_idx_i), .req_bhr_i(req_bhr_i),
        .req_sum_i(req_sum_i), .req_taken_i(req_taken_i),
        .rd_en_o(rd_en_o), .rd_idx_o(rd_idx_o), .rd_weight_i(rd_weight_i),
        .wr_en_o(wr_en_o), .wr_idx_o(wr_idx_o), .wr_weight_o(wr_weight_o),
        .wr_ready_i(wr_ready_i), .busy_o(busy_o)
`ifdef PERCEPTRON_TRAIN_STAT_EN
        , .train_cnt_o(train_cnt), .skip_cnt_o(skip_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural weight table ----------------
    logic [ROW_W-1:0]    mem [ROWS];
    logic                load_en;
    logic [PT_IDX_W-1:0] load_idx;
    logic [ROW_W-1:0]    load_row;

    always @(posedge clk) begin
        if (rd_en_o) rd_weight_i <= mem[rd_idx_o];
        if (wr_en_o && wr_ready_i) mem[wr_idx_o] <= wr_weight_o;
        if (load_en) mem[load_idx] <= load_row;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [PT_IDX_W-1:0] idx;
        logic [BHR_W-1:0]    bhr;
        logic [SUM_W-1:0]    sum;
        logic                taken;
    } rec_t;

    rec_t             sb_q[$];
    logic [ROW_W-1:0] model_mem [ROWS];
    int               errors = 0;
    int               checks = 0;
    int               wr_count = 0;
    bit               rand_wr = 0;

    function automatic bit needs_train(logic [SUM_W-1:0] sum, logic taken);
        int s;
        s = int'($signed(sum));
        return ((s < 0) != taken) || ((s >= -THETA) && (s <= THETA));
    endfunction

    function automatic logic [ROW_W-1:0] train_row(logic [ROW_W-1:0] row,
                                                   logic [BHR_W-1:0] bhr,
                                                   logic taken);
        logic [ROW_W-1:0] r;
        int w;
        logic x;
        r = '0;
        for (int i = 0; i <= BHR_W; i++) begin
            w = int'($signed(row[i*WEIGHT_W +: WEIGHT_W]));
            x = (i == 0) ? 1'b1 : bhr[i-1];
            w = w + ((x == taken) ? 1 : -1);
            if (w > (2**(WEIGHT_W-1)) - 1) w = (2**(WEIGHT_W-1)) - 1;
            if (w < -(2**(WEIGHT_W-1)))    w = -(2**(WEIGHT_W-1));
            r[i*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(w);
        end
        return r;
    endfunction

    task automatic check(string name, logic [ROW_W-1:0] act, logic [ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Observes the DUT each falling edge: predicts read indices and written
    // rows from the queue of accepted records and the shadow table.
    task automatic monitor_loop();
        rec_t r;
        logic [ROW_W-1:0] exp_row;
        int k;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                continue;
            end
            if (load_en) model_mem[load_idx] = load_row;
            if (rd_en_o) begin
                k = 0;
                while (k < sb_q.size() && !needs_train(sb_q[k].sum, sb_q[k].taken)) k++;
                if (k >= sb_q.size()) begin
                    checks++; errors++;
                    $display("FAIL rd_expected: got read of row %0d required no read", rd_idx_o);
                end else begin
                    check("rd_idx", ROW_W'(rd_idx_o), ROW_W'(sb_q[k].idx));
                end
            end
            if (wr_en_o && wr_ready_i) begin
                wr_count++;
                while (sb_q.size() > 0 && !needs_train(sb_q[0].sum, sb_q[0].taken))
                    void'(sb_q.pop_front());
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_expected: got write of row %0d required no write", wr_idx_o);
                end else begin
                    r = sb_q.pop_front();
                    exp_row = train_row(model_mem[r.idx], r.bhr, r.taken);
                    check("wr_idx", ROW_W'(wr_idx_o), ROW_W'(r.idx));
                    check("wr_row", wr_weight_o, exp_row);
                    model_mem[r.idx] = exp_row;
                end
            end
            if (req_valid_i && req_ready_o)
                sb_q.push_back('{req_idx_i, req_bhr_i, req_sum_i, req_taken_i});
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            if (rand_wr) wr_ready_i = ($urandom_range(0, 9) < 7);
        end
    endtask

    // ---------------- stimulus helpers (start/end at posedge+1) ----------------
    task automatic load(input logic [PT_IDX_W-1:0] idx, input logic [ROW_W-1:0] row);
        load_idx = idx; load_row = row; load_en = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic drive(input logic [PT_IDX_W-1:0] idx, input logic [BHR_W-1:0] bhr,
                         input logic [SUM_W-1:0] sum, input logic taken);
        req_idx_i = idx; req_bhr_i = bhr; req_sum_i = sum; req_taken_i = taken;
        req_valid_i = 1'b1;
    endtask

    task automatic push(input logic [PT_IDX_W-1:0] idx, input logic [BHR_W-1:0] bhr,
                        input logic [SUM_W-1:0] sum, input logic taken);
        bit done;
        done = 0;
        drive(idx, bhr, sum, taken);
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (req_ready_o) done = 1;
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL push_timeout: got req_ready_o=0 for 200 cycles required 1");
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int t = 0; t < budget && !done; t++) begin
            @(negedge clk);
            if (!busy_o) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy_o=1 required 0 within %0d cycles", budget);
        end
        @(posedge clk); #1;
    endtask

    // Enqueue one record and return the row seen on the first wr_en_o cycle.
    task automatic run_until_write(input logic [PT_IDX_W-1:0] idx, input logic [BHR_W-1:0] bhr,
                                   input logic [SUM_W-1:0] sum, input logic taken,
                                   output logic [ROW_W-1:0] got);
        bit done;
        done = 0;
        got = '0;
        drive(idx, bhr, sum, taken);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (wr_en_o) begin
                got = wr_weight_o;
                done = 1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL wr_timeout: got wr_en_o=0 required 1 within 20 cycles");
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [SUM_W-1:0] sum;
        logic             taken;
        logic [BHR_W-1:0] bhr;
        logic             exp_train;
    } vec_t;

    vec_t             vt [11];
    logic [ROW_W-1:0] exp_row;
    logic [ROW_W-1:0] got_row;
    logic [ROW_W-1:0] held_row;
    logic [PT_IDX_W-1:0] held_idx;
    bit               saw_rd;
    bit               done_v;
    int               wr_before;
    int               left_train;

    initial begin
        rst_n = 1'b0; req_valid_i = 1'b0; req_idx_i = '0; req_bhr_i = '0;
        req_sum_i = '0; req_taken_i = 1'b0; wr_ready_i = 1'b1;
        load_en = 1'b0; load_idx = '0; load_row = '0;

        vt[0]  = '{SUM_W'(5),     1'b1, 8'b1010_0000, 1'b1};
        vt[1]  = '{SUM_W'(-40),   1'b1, 8'h3C,        1'b0};
        vt[2]  = '{SUM_W'(29),    1'b0, 8'h11,        1'b1};
        vt[3]  = '{SUM_W'(30),    1'b0, 8'h22,        1'b0};
        vt[4]  = '{SUM_W'(-2048), 1'b1, 8'h44,        1'b0};
        vt[5]  = '{SUM_W'(-29),   1'b1, 8'h81,        1'b1};
        vt[6]  = '{SUM_W'(-30),   1'b1, 8'h18,        1'b0};
        vt[7]  = '{SUM_W'(2047),  1'b1, 8'hF0,        1'b1};
        vt[8]  = '{SUM_W'(-2048), 1'b0, 8'h0F,        1'b1};
        vt[9]  = '{SUM_W'(0),     1'b0, 8'hAA,        1'b1};
        vt[10] = '{SUM_W'(30),    1'b1, 8'h55,        1'b1};

        fork
            monitor_loop();
            ready_driver();
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", ROW_W'(req_ready_o), ROW_W'(1));
        check("rst_busy",      ROW_W'(busy_o),      ROW_W'(0));
        check("rst_rd_en",     ROW_W'(rd_en_o),     ROW_W'(0));
        check("rst_wr_en",     ROW_W'(wr_en_o),     ROW_W'(0));
        check("rst_wr_idx",    ROW_W'(wr_idx_o),    ROW_W'(0));
        check("rst_wr_weight", wr_weight_o,         ROW_W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < ROWS; i++)
            load(PT_IDX_W'(i), {$urandom, $urandom, $urandom});

        // Mispredict timing and row contents
        load(PT_IDX_W'(3), '0);
        exp_row = '0;
        for (int i = 0; i <= BHR_W; i++)
            exp_row[i*WEIGHT_W +: WEIGHT_W] = (i == 0 || i == 6 || i == 8) ? 8'h01 : 8'hFF;
        drive(PT_IDX_W'(3), 8'b1010_0000, SUM_W'(5), 1'b1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk); check("mp_rd_c1", ROW_W'(rd_en_o), ROW_W'(0));
        @(negedge clk); check("mp_rd_c2", ROW_W'(rd_en_o), ROW_W'(1));
                        check("mp_rd_idx", ROW_W'(rd_idx_o), ROW_W'(3));
        @(negedge clk); check("mp_wr_c3", ROW_W'(wr_en_o), ROW_W'(0));
        @(negedge clk); check("mp_wr_c4", ROW_W'(wr_en_o), ROW_W'(1));
                        check("mp_wr_row", wr_weight_o, exp_row);
        @(negedge clk); check("mp_wr_done", ROW_W'(wr_en_o), ROW_W'(0));
                        check("mp_busy_done", ROW_W'(busy_o), ROW_W'(0));
        @(posedge clk); #1;

        // Confident correct prediction retires in one cycle
        drive(PT_IDX_W'(4), 8'h00, SUM_W'(-40), 1'b1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk); check("cc_busy_c1", ROW_W'(busy_o), ROW_W'(1));
                        check("cc_rd_c1",   ROW_W'(rd_en_o), ROW_W'(0));
        @(negedge clk); check("cc_busy_c2", ROW_W'(busy_o), ROW_W'(0));
                        check("cc_rd_c2",   ROW_W'(rd_en_o), ROW_W'(0));
        @(posedge clk); #1;

        // Train/skip decision table
        for (int v = 0; v < 11; v++) begin
            saw_rd = 0;
            done_v = 0;
            drive(PT_IDX_W'(16 + v), vt[v].bhr, vt[v].sum, vt[v].taken);
            @(posedge clk); #1;
            req_valid_i = 1'b0;
            for (int t = 0; t < 20 && !done_v; t++) begin
                @(negedge clk);
                if (rd_en_o) saw_rd = 1;
                if (!busy_o) done_v = 1;
            end
            if (!done_v) begin
                checks++; errors++;
                $display("FAIL vec%0d_timeout: got busy_o=1 required 0", v);
            end
            check($sformatf("vec%0d_train sum=%0d taken=%0d", v, $signed(vt[v].sum), vt[v].taken),
                  ROW_W'(saw_rd), ROW_W'(vt[v].exp_train));
            @(posedge clk); #1;
        end

        // Saturation at both rails
        load(PT_IDX_W'(5), ROW_W'(8'h7F));
        run_until_write(PT_IDX_W'(5), 8'h00, SUM_W'(5), 1'b1, got_row);
        check("sat_w0_max", ROW_W'(got_row[7:0]), ROW_W'(8'h7F));
        wait_idle(20);
        load(PT_IDX_W'(6), ROW_W'(16'h8000));
        run_until_write(PT_IDX_W'(6), 8'h01, SUM_W'(-5), 1'b0, got_row);
        check("sat_w1_min", ROW_W'(got_row[15:8]), ROW_W'(8'h80));
        wait_idle(20);

        // Backpressure: fill the FIFO while the write is stalled
        wr_ready_i = 1'b0;
        wr_before = wr_count;
        for (int j = 0; j < 4; j++) begin
            drive(PT_IDX_W'(20 + j), 8'($urandom), SUM_W'(0), 1'(j));
            @(negedge clk);
            check("bp_ready_pre", ROW_W'(req_ready_o), ROW_W'(1));
            @(posedge clk); #1;
        end
        drive(PT_IDX_W'(24), 8'h5A, SUM_W'(-3), 1'b0);
        @(negedge clk);
        check("bp_full", ROW_W'(req_ready_o), ROW_W'(0));
        check("bp_wr_en", ROW_W'(wr_en_o), ROW_W'(1));
        held_row = wr_weight_o;
        held_idx = wr_idx_o;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("bp_hold_ready", ROW_W'(req_ready_o), ROW_W'(0));
            check("bp_hold_wr_en", ROW_W'(wr_en_o), ROW_W'(1));
            check("bp_hold_row", wr_weight_o, held_row);
            check("bp_hold_idx", ROW_W'(wr_idx_o), ROW_W'(held_idx));
        end
        @(posedge clk); #1;
        wr_ready_i = 1'b1;
        @(negedge clk);
        check("bp_pop_cycle_ready", ROW_W'(req_ready_o), ROW_W'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_ready_after_pop", ROW_W'(req_ready_o), ROW_W'(1));
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        wait_idle(100);
        check("bp_write_count", ROW_W'(wr_count - wr_before), ROW_W'(5));

        // Reset while a write is pending
        wr_ready_i = 1'b0;
        drive(PT_IDX_W'(30), 8'hC3, SUM_W'(1), 1'b1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        done_v = 0;
        for (int t = 0; t < 20 && !done_v; t++) begin
            @(negedge clk);
            if (wr_en_o) done_v = 1;
        end
        check("rw_reach_write", ROW_W'(done_v), ROW_W'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rw_async_wr_en", ROW_W'(wr_en_o), ROW_W'(0));
        check("rw_async_busy",  ROW_W'(busy_o),  ROW_W'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_ready_i = 1'b1;
        @(negedge clk);
        check("rw_after_busy",  ROW_W'(busy_o),      ROW_W'(0));
        check("rw_after_ready", ROW_W'(req_ready_o), ROW_W'(1));
        check("rw_after_wr_en", ROW_W'(wr_en_o),     ROW_W'(0));
        @(posedge clk); #1;

        // Randomized traffic on a few rows with random write backpressure
        rand_wr = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            if ($urandom_range(0, 1) == 1)
                push(PT_IDX_W'($urandom_range(0, 7)), 8'($urandom),
                     SUM_W'(int'($urandom_range(0, 80)) - 40), 1'($urandom));
            else
                push(PT_IDX_W'($urandom_range(0, 7)), 8'($urandom),
                     SUM_W'($urandom), 1'($urandom));
        end
        rand_wr = 0;
        @(posedge clk); #1;
        wr_ready_i = 1'b1;
        wait_idle(200);

        left_train = 0;
        foreach (sb_q[k]) if (needs_train(sb_q[k].sum, sb_q[k].taken)) left_train++;
        check("drain_pending_trains", ROW_W'(left_train), ROW_W'(0));
        for (int i = 0; i < ROWS; i++)
            check($sformatf("table_row%0d", i), mem[i], model_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
